// File: rtl/bpsk_tx_sequencer_if.sv
// Byte-stream input and modulator-side outputs of the BPSK transmit sequencer.
interface bpsk_tx_sequencer_if;
   logic [7:0] s_tdata;
   logic       s_tvalid;
   logic       s_tlast;
   logic       s_tready;
   logic       mod_en;
   logic       mod_in;
   logic       sym_strobe;
   logic       busy;
   logic       frame_done;
   logic       underrun;

   modport master (
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready, mod_en, mod_in, sym_strobe, busy, frame_done, underrun
   );

   modport slave (
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready, mod_en, mod_in, sym_strobe, busy, frame_done, underrun
   );
endinterface

// File: rtl/bpsk_tx_sequencer.sv
// Frames a byte stream as preamble + sync word + payload and serialises it
// into symbol-rate bits (each held SAMPLES_PER_SYM clocks) for the BPSK modulator.
module bpsk_tx_sequencer #(
   parameter int unsigned SAMPLES_PER_SYM = 20,
   parameter int unsigned PREAMBLE_LEN    = 16,
   parameter logic [7:0]  SYNC_WORD       = 8'hD3
) (
   input  logic                clk,
   input  logic                rst_n,
   bpsk_tx_sequencer_if.slave  bus
);

   localparam int unsigned SYM_W = (SAMPLES_PER_SYM > 2) ? $clog2(SAMPLES_PER_SYM) : 1;
   localparam int unsigned BIT_W = (PREAMBLE_LEN > 8) ? $clog2(PREAMBLE_LEN) : 3;
   localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SAMPLES_PER_SYM - 1);
   localparam logic [BIT_W-1:0] PRE_LAST  = BIT_W'(PREAMBLE_LEN - 1);
   localparam logic [BIT_W-1:0] BYTE_LAST = BIT_W'(7);

   typedef enum logic [1:0] {IDLE, PREAMBLE, SYNC, PAYLOAD} state_t;

   state_t           state_q, state_d;
   logic [SYM_W-1:0] sym_cnt_q, sym_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [7:0]       hold_data_q, hold_data_d;
   logic             hold_full_q, hold_full_d;
   logic             hold_last_q, hold_last_d;
   logic [7:0]       shift_q, shift_d;
   logic             shift_last_q, shift_last_d;
   logic             last_seen_q, last_seen_d;
   logic             mod_en_q, mod_en_d;
   logic             mod_in_q, mod_in_d;
   logic             sym_strobe_q, sym_strobe_d;
   logic             busy_q, busy_d;
   logic             frame_done_q, frame_done_d;
   logic             underrun_q, underrun_d;

   logic ready_c;
   logic handshake_c;
   logic boundary_c;

   // Ready is forced low while reset is held so nothing is offered mid-reset.
   assign ready_c     = rst_n && !hold_full_q && !last_seen_q;
   assign handshake_c = bus.s_tvalid && ready_c;
   assign boundary_c  = (sym_cnt_q == SYM_LAST);

   always_comb begin
      state_d      = state_q;
      sym_cnt_d    = sym_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      hold_data_d  = hold_data_q;
      hold_full_d  = hold_full_q;
      hold_last_d  = hold_last_q;
      shift_d      = shift_q;
      shift_last_d = shift_last_q;
      last_seen_d  = last_seen_q;
      mod_in_d     = mod_in_q;
      frame_done_d = 1'b0;
      underrun_d   = 1'b0;

      if (state_q != IDLE) begin
         sym_cnt_d = boundary_c ? '0 : sym_cnt_q + SYM_W'(1);
      end

      if (handshake_c) begin
         hold_data_d = bus.s_tdata;
         hold_last_d = bus.s_tlast;
         hold_full_d = 1'b1;
         last_seen_d = last_seen_q | bus.s_tlast;
      end

      case (state_q)
         IDLE: begin
            if (handshake_c) begin
               state_d   = PREAMBLE;
               bit_cnt_d = '0;
               mod_in_d  = 1'b1;
            end
         end
         PREAMBLE: begin
            if (boundary_c) begin
               if (bit_cnt_q == PRE_LAST) begin
                  state_d   = SYNC;
                  bit_cnt_d = '0;
                  mod_in_d  = SYNC_WORD[7];
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  mod_in_d  = bit_cnt_q[0];
               end
            end
         end
         SYNC: begin
            if (boundary_c) begin
               if (bit_cnt_q == BYTE_LAST) begin
                  state_d      = PAYLOAD;
                  bit_cnt_d    = '0;
                  shift_d      = hold_data_q;
                  shift_last_d = hold_last_q;
                  hold_full_d  = handshake_c;
                  mod_in_d     = hold_data_q[7];
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  mod_in_d  = SYNC_WORD[3'(3'd6 - bit_cnt_q[2:0])];
               end
            end
         end
         PAYLOAD: begin
            if (boundary_c) begin
               if (bit_cnt_q != BYTE_LAST) begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
                  shift_d   = {shift_q[6:0], 1'b0};
                  mod_in_d  = shift_q[6];
               end else if (shift_last_q) begin
                  state_d      = IDLE;
                  frame_done_d = 1'b1;
                  last_seen_d  = 1'b0;
               end else if (hold_full_q) begin
                  bit_cnt_d    = '0;
                  shift_d      = hold_data_q;
                  shift_last_d = hold_last_q;
                  hold_full_d  = handshake_c;
                  mod_in_d     = hold_data_q[7];
               end else if (handshake_c) begin
                  // Byte arriving exactly on the boundary bypasses the holding register.
                  bit_cnt_d    = '0;
                  shift_d      = bus.s_tdata;
                  shift_last_d = bus.s_tlast;
                  hold_full_d  = 1'b0;
                  mod_in_d     = bus.s_tdata[7];
               end else begin
                  state_d     = IDLE;
                  underrun_d  = 1'b1;
                  last_seen_d = 1'b0;
               end
            end
         end
      endcase

      if (state_d == IDLE) begin
         mod_in_d = 1'b0;
      end
      mod_en_d     = (state_d != IDLE);
      busy_d       = (state_d != IDLE);
      sym_strobe_d = busy_d && (sym_cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sym_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         hold_data_q  <= '0;
         hold_full_q  <= 1'b0;
         hold_last_q  <= 1'b0;
         shift_q      <= '0;
         shift_last_q <= 1'b0;
         last_seen_q  <= 1'b0;
         mod_en_q     <= 1'b0;
         mod_in_q     <= 1'b0;
         sym_strobe_q <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sym_cnt_q    <= sym_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         hold_data_q  <= hold_data_d;
         hold_full_q  <= hold_full_d;
         hold_last_q  <= hold_last_d;
         shift_q      <= shift_d;
         shift_last_q <= shift_last_d;
         last_seen_q  <= last_seen_d;
         mod_en_q     <= mod_en_d;
         mod_in_q     <= mod_in_d;
         sym_strobe_q <= sym_strobe_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         underrun_q   <= underrun_d;
      end
   end

   assign bus.s_tready   = ready_c;
   assign bus.mod_en     = mod_en_q;
   assign bus.mod_in     = mod_in_q;
   assign bus.sym_strobe = sym_strobe_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.underrun   = underrun_q;

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Directed bench for bpsk_tx_sequencer: a frame-level model predicts every
// output each cycle, plus literal checks at hand-computed cycles.
module tb_bpsk_tx_sequencer;
   localparam int unsigned S  = 20;
   localparam int unsigned PL = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bpsk_tx_sequencer_if bus();

   bpsk_tx_sequencer #(
      .SAMPLES_PER_SYM(S),
      .PREAMBLE_LEN   (PL),
      .SYNC_WORD      (8'hD3)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int stb_cnt = 0;
   always @(negedge clk) if (bus.sym_strobe === 1'b1) stb_cnt <= stb_cnt + 1;

   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;

   // Expected frames: start cycle, symbol list, and how the frame ends (1 done, 2 underrun).
   int   f_start [2];
   int   f_len   [2];
   int   f_kind  [2];
   logic f_bit   [2][64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   task automatic clear_frames();
      f_len[0] = 0;
      f_len[1] = 0;
   endtask

   task automatic set_frame(input int s, input int start, input logic [7:0] b0,
                            input logic [7:0] b1, input logic [7:0] b2,
                            input int n, input int kind);
      logic [7:0] sw;
      logic [7:0] cur;
      int k;
      sw = 8'hD3;
      k  = 0;
      for (int i = 0; i < int'(PL); i++) begin
         f_bit[s][k] = ((i % 2) == 0);
         k++;
      end
      for (int i = 0; i < 8; i++) begin
         f_bit[s][k] = sw[7-i];
         k++;
      end
      for (int j = 0; j < n; j++) begin
         cur = (j == 0) ? b0 : ((j == 1) ? b1 : b2);
         for (int i = 0; i < 8; i++) begin
            f_bit[s][k] = cur[7-i];
            k++;
         end
      end
      f_start[s] = start;
      f_kind[s]  = kind;
      f_len[s]   = k;
   endtask

   task automatic model_check();
      logic e_en, e_in, e_stb, e_bsy, e_dn, e_ur;
      int   rel, span;
      e_en = 0; e_in = 0; e_stb = 0; e_bsy = 0; e_dn = 0; e_ur = 0;
      for (int s = 0; s < 2; s++) begin
         if (f_len[s] > 0) begin
            rel  = cyc - f_start[s];
            span = f_len[s] * int'(S);
            if (rel >= 0 && rel < span) begin
               e_en  = 1'b1;
               e_bsy = 1'b1;
               e_in  = f_bit[s][rel / int'(S)];
               e_stb = ((rel % int'(S)) == 0);
            end else if (rel == span) begin
               e_dn = (f_kind[s] == 1);
               e_ur = (f_kind[s] == 2);
            end
         end
      end
      chk("mod_en", 32'(bus.mod_en), 32'(e_en));
      chk("busy", 32'(bus.busy), 32'(e_bsy));
      chk("sym_strobe", 32'(bus.sym_strobe), 32'(e_stb));
      chk("frame_done", 32'(bus.frame_done), 32'(e_dn));
      chk("underrun", 32'(bus.underrun), 32'(e_ur));
      if (e_en) chk("mod_in", 32'(bus.mod_in), 32'(e_in));
   endtask

   task automatic go_pos(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go_neg(input int c);
      do @(negedge clk); while (cyc < c);
   endtask

   task automatic push_byte(input logic [7:0] d, input logic l);
      logic got;
      got = 1'b0;
      bus.s_tdata  = d;
      bus.s_tvalid = 1'b1;
      bus.s_tlast  = l;
      for (int n = 0; n < 2000 && !got; n++) begin
         @(negedge clk);
         if (bus.s_tready === 1'b1) got = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("handshake", 32'(got), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   int t0, t1, base;

   initial begin
      rst_n        = 1'b0;
      bus.s_tdata  = 8'h00;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
      clear_frames();

      fork
         forever begin
            @(negedge clk);
            if (chk_en) model_check();
         end
      join_none

      // Reset state
      go_neg(2);
      chk("rst_mod_en", 32'(bus.mod_en), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_ready", 32'(bus.s_tready), 0);
      go_pos(3);
      rst_n = 1'b1;
      go_neg(3);
      chk("idle_ready", 32'(bus.s_tready), 1);
      chk_en = 1'b1;

      // 1: single 0xA5 frame
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'hA5, 8'h00, 8'h00, 1, 1);
      base = stb_cnt;
      bus.s_tdata = 8'hA5; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1;
      go_neg(t0);
      chk("t1_ready", 32'(bus.s_tready), 1);
      go_pos(t0 + 1);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 1);
      chk("t1_first_strobe", 32'(bus.sym_strobe), 1);
      chk("t1_first_bit", 32'(bus.mod_in), 1);
      go_neg(t0 + 321);
      chk("t1_sync_bit0", 32'(bus.mod_in), 1);
      go_neg(t0 + 361);
      chk("t1_sync_bit2", 32'(bus.mod_in), 0);
      go_neg(t0 + 640);
      chk("t1_en_last", 32'(bus.mod_en), 1);
      go_neg(t0 + 641);
      chk("t1_done", 32'(bus.frame_done), 1);
      chk("t1_en_off", 32'(bus.mod_en), 0);
      go_neg(t0 + 645);
      chk("t1_strobes", 32'(stb_cnt - base), 32);

      // 2: three bytes, source always valid
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'h00, 8'hFF, 8'h81, 3, 1);
      push_byte(8'h00, 1'b0);
      @(negedge clk); chk("t2_ready_drop0", 32'(bus.s_tready), 0);
      @(posedge clk); #1;
      push_byte(8'hFF, 1'b0);
      @(negedge clk); chk("t2_ready_drop1", 32'(bus.s_tready), 0);
      @(posedge clk); #1;
      push_byte(8'h81, 1'b1);
      @(negedge clk); chk("t2_ready_drop2", 32'(bus.s_tready), 0);
      @(posedge clk); #1;
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 900);
      chk("t2_ready_after_last", 32'(bus.s_tready), 0);
      go_neg(t0 + 960);
      chk("t2_en_last", 32'(bus.mod_en), 1);
      go_neg(t0 + 961);
      chk("t2_done", 32'(bus.frame_done), 1);
      go_neg(t0 + 965);

      // 3: underrun
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'h3C, 8'h00, 8'h00, 1, 2);
      push_byte(8'h3C, 1'b0);
      bus.s_tvalid = 1'b0;
      go_neg(t0 + 641);
      chk("t3_underrun", 32'(bus.underrun), 1);
      chk("t3_busy", 32'(bus.busy), 0);
      chk("t3_en", 32'(bus.mod_en), 0);
      chk("t3_no_done", 32'(bus.frame_done), 0);
      go_neg(t0 + 645);

      // 4: second byte arrives on the last cycle of bit 0
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'h5A, 8'hC3, 8'h00, 2, 1);
      push_byte(8'h5A, 1'b0);
      bus.s_tvalid = 1'b0;
      go_pos(t0 + 640);
      bus.s_tdata = 8'hC3; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1;
      go_neg(t0 + 640);
      chk("t4_ready", 32'(bus.s_tready), 1);
      go_pos(t0 + 641);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 641);
      chk("t4_seamless_en", 32'(bus.mod_en), 1);
      chk("t4_seamless_bit", 32'(bus.mod_in), 1);
      go_neg(t0 + 801);
      chk("t4_done", 32'(bus.frame_done), 1);
      go_neg(t0 + 805);

      // 5: reset during payload, then a clean frame
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'h96, 8'h00, 8'h00, 1, 1);
      push_byte(8'h96, 1'b1);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 549);
      chk("t5_pre_en", 32'(bus.mod_en), 1);
      chk("t5_pre_bit", 32'(bus.mod_in), 1);
      go_pos(t0 + 550);
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("t5_rst_en", 32'(bus.mod_en), 0);
      chk("t5_rst_in", 32'(bus.mod_in), 0);
      chk("t5_rst_busy", 32'(bus.busy), 0);
      chk("t5_rst_ready", 32'(bus.s_tready), 0);
      go_pos(t0 + 553);
      rst_n = 1'b1;
      clear_frames();
      go_pos(t0 + 555);
      chk_en = 1'b1;
      t1 = cyc;
      set_frame(0, t1 + 1, 8'h4B, 8'h00, 8'h00, 1, 1);
      bus.s_tdata = 8'h4B; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1;
      go_neg(t1);
      chk("t5_ready_after_rst", 32'(bus.s_tready), 1);
      go_pos(t1 + 1);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t1 + 641);
      chk("t5_done", 32'(bus.frame_done), 1);
      go_neg(t1 + 645);

      // 6: back-to-back frames
      go_pos(cyc + 2);
      t0 = cyc;
      clear_frames();
      set_frame(0, t0 + 1, 8'h11, 8'h00, 8'h00, 1, 1);
      set_frame(1, t0 + 642, 8'hE7, 8'h00, 8'h00, 1, 1);
      push_byte(8'h11, 1'b1);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 640);
      chk("t6_ready_in_frame", 32'(bus.s_tready), 0);
      go_pos(t0 + 641);
      bus.s_tdata = 8'hE7; bus.s_tvalid = 1'b1; bus.s_tlast = 1'b1;
      go_neg(t0 + 641);
      chk("t6_done", 32'(bus.frame_done), 1);
      chk("t6_gap_en", 32'(bus.mod_en), 0);
      chk("t6_ready_idle", 32'(bus.s_tready), 1);
      go_pos(t0 + 642);
      bus.s_tvalid = 1'b0; bus.s_tlast = 1'b0;
      go_neg(t0 + 642);
      chk("t6_second_en", 32'(bus.mod_en), 1);
      chk("t6_second_strobe", 32'(bus.sym_strobe), 1);
      go_neg(t0 + 642 + 640);
      chk("t6_second_done", 32'(bus.frame_done), 1);
      go_neg(t0 + 642 + 645);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
